// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 2^N input combinations into a pair of DUTs,
// waits SETTLE cycles per combination, samples both responses and reports
// mismatches, the first failing vector and an overall pass flag.
// Optional macro TRUTH_TABLE_GOLDEN_EN: also checks both responses against the
// OR-reduction golden value and adds the sticky golden_fail output.
module truth_table_checker #(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [N-1:0] stim,
    input  logic         resp_a,
    input  logic         resp_b,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   mismatch_cnt,
    output logic [N-1:0] first_fail,
`ifdef TRUTH_TABLE_GOLDEN_EN
    output logic         golden_fail,
`endif
    output logic         first_fail_vld
);

    localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [N-1:0]     STIM_LAST = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     stim_d;
    logic             busy_d, done_d, pass_d;
    logic [N:0]       mismatch_cnt_d;
    logic [N-1:0]     first_fail_d;
    logic             first_fail_vld_d;
    logic             fail_c;
`ifdef TRUTH_TABLE_GOLDEN_EN
    logic             golden_fail_d;
    logic             golden_c;
`endif

    // Failure condition for the combination currently on stim; X/Z count as failing
`ifdef TRUTH_TABLE_GOLDEN_EN
    always_comb begin
        golden_c = |stim;
        fail_c   = (resp_a !== golden_c) || (resp_b !== golden_c);
    end
`else
    always_comb begin
        fail_c = (resp_a !== resp_b);
    end
`endif

    // Next-state and next-output logic for the sweep controller
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        stim_d           = stim;
        busy_d           = busy;
        done_d           = done;
        pass_d           = pass;
        mismatch_cnt_d   = mismatch_cnt;
        first_fail_d     = first_fail;
        first_fail_vld_d = first_fail_vld;
`ifdef TRUTH_TABLE_GOLDEN_EN
        golden_fail_d    = golden_fail;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Fresh sweep: results cleared in the same cycle done drops
                    state_d          = DRIVE;
                    cnt_d            = '0;
                    stim_d           = '0;
                    busy_d           = 1'b1;
                    done_d           = 1'b0;
                    pass_d           = 1'b0;
                    mismatch_cnt_d   = '0;
                    first_fail_d     = '0;
                    first_fail_vld_d = 1'b0;
`ifdef TRUTH_TABLE_GOLDEN_EN
                    golden_fail_d    = 1'b0;
`endif
                end else if (state_q == DONE) begin
                    // Results already include the final sample here
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (mismatch_cnt == '0);
                end
            end

            DRIVE: begin
                // Hold stim for SETTLE cycles before sampling
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SAMPLE: begin
                if (fail_c) begin
                    mismatch_cnt_d = mismatch_cnt + (N+1)'(1);
                    if (!first_fail_vld) begin
                        first_fail_d     = stim;
                        first_fail_vld_d = 1'b1;
                    end
`ifdef TRUTH_TABLE_GOLDEN_EN
                    golden_fail_d = 1'b1;
`endif
                end
                if (stim == STIM_LAST) begin
                    state_d = DONE;
                end else begin
                    stim_d  = stim + N'(1);
                    state_d = DRIVE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset overrides start and every transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stim           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
`ifdef TRUTH_TABLE_GOLDEN_EN
            golden_fail    <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stim           <= stim_d;
            busy           <= busy_d;
            done           <= done_d;
            pass           <= pass_d;
            mismatch_cnt   <= mismatch_cnt_d;
            first_fail     <= first_fail_d;
            first_fail_vld <= first_fail_vld_d;
`ifdef TRUTH_TABLE_GOLDEN_EN
            golden_fail    <= golden_fail_d;
`endif
        end
    end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: DUT responses come from per-combination truth
// tables held here; expected results come from a sweep over those tables.
module tb_truth_table_checker;

    localparam int NN     = 2;
    localparam int SS     = 1;
    localparam int COMBOS = 1 << NN;
    localparam int SWEEP  = COMBOS * (SS + 1);
    localparam int BUDGET = SWEEP + 20;
    localparam logic [COMBOS-1:0] OR_TBL  = 4'b1110;
    localparam logic [COMBOS-1:0] AND_TBL = 4'b1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NN-1:0] stim;
    logic          resp_a, resp_b;
    logic          busy, done, pass;
    logic [NN:0]   mismatch_cnt;
    logic [NN-1:0] first_fail;
    logic          first_fail_vld;
`ifdef TRUTH_TABLE_GOLDEN_EN
    logic          golden_fail;
`endif

    logic [COMBOS-1:0] tbl_a, tbl_b;

    int checks = 0;
    int errors = 0;

    assign resp_a = tbl_a[stim];
    assign resp_b = tbl_b[stim];

    always #5 clk = ~clk;

    truth_table_checker #(.N(NN), .SETTLE(SS)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stim           (stim),
        .resp_a         (resp_a),
        .resp_b         (resp_b),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .mismatch_cnt   (mismatch_cnt),
        .first_fail     (first_fail),
`ifdef TRUTH_TABLE_GOLDEN_EN
        .golden_fail    (golden_fail),
`endif
        .first_fail_vld (first_fail_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sweep outcome from the current truth tables
    function automatic void model(output int cnt, output int first, output bit vld, output bit gfail);
        bit a, b, g, f;
        cnt = 0; first = 0; vld = 0; gfail = 0;
        for (int i = 0; i < COMBOS; i++) begin
            a = tbl_a[i];
            b = tbl_b[i];
            g = (i != 0);
`ifdef TRUTH_TABLE_GOLDEN_EN
            f = (a != g) || (b != g);
`else
            f = (a != b);
`endif
            if (f) begin
                cnt++;
                if (!vld) begin
                    first = i;
                    vld   = 1;
                end
`ifdef TRUTH_TABLE_GOLDEN_EN
                gfail = 1;
`endif
            end
        end
    endfunction

    // One full sweep; optional extra start pulse while busy at observation busy_pulse_at
    task automatic do_sweep(input string name, input int busy_pulse_at);
        int exp_cnt, exp_first, lat;
        bit exp_vld, exp_gf, seq_ok;
        model(exp_cnt, exp_first, exp_vld, exp_gf);
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || mismatch_cnt !== '0 || first_fail_vld !== 1'b0) begin
            errors++;
            $display("FAIL %s start_clear: busy=%b done=%b cnt=%0d vld=%b, expected 1 0 0 0",
                     name, busy, done, mismatch_cnt, first_fail_vld);
        end
        lat = -1;
        seq_ok = 1;
        for (int c = 0; c <= BUDGET; c++) begin
            if (done === 1'b1) begin
                lat = c;
                break;
            end
            if (c < SWEEP && (stim !== NN'(c / (SS + 1)) || busy !== 1'b1)) begin
                if (seq_ok)
                    $display("FAIL %s stim_seq: at cycle %0d stim=%0d busy=%b, expected %0d 1",
                             name, c, stim, busy, c / (SS + 1));
                seq_ok = 0;
            end
            start = (busy_pulse_at != 0 && c == busy_pulse_at);
            tick();
        end
        start = 1'b0;
        checks++;
        if (!seq_ok) errors++;
        checks++;
        if (lat != SWEEP + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, SWEEP + 1);
        end
        checks++;
        if (pass !== (exp_cnt == 0) || mismatch_cnt !== (NN+1)'(exp_cnt)) begin
            errors++;
            $display("FAIL %s result: pass=%b cnt=%0d, expected %b %0d",
                     name, pass, mismatch_cnt, exp_cnt == 0, exp_cnt);
        end
        checks++;
        if (first_fail_vld !== exp_vld || first_fail !== NN'(exp_first)) begin
            errors++;
            $display("FAIL %s first_fail: vld=%b val=%0d, expected %b %0d",
                     name, first_fail_vld, first_fail, exp_vld, exp_first);
        end
        checks++;
        if (busy !== 1'b0 || stim !== {NN{1'b1}}) begin
            errors++;
            $display("FAIL %s done_state: busy=%b stim=%0d, expected 0 %0d", name, busy, stim, COMBOS - 1);
        end
`ifdef TRUTH_TABLE_GOLDEN_EN
        checks++;
        if (golden_fail !== exp_gf) begin
            errors++;
            $display("FAIL %s golden_fail: got %b expected %b", name, golden_fail, exp_gf);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        tick(); tick();
        checks++;
        if (busy !== 0 || done !== 0 || pass !== 0 || stim !== '0 || mismatch_cnt !== '0 ||
            first_fail !== '0 || first_fail_vld !== 0) begin
            errors++;
            $display("FAIL reset: busy=%b done=%b pass=%b stim=%0d cnt=%0d ff=%0d vld=%b, expected all 0",
                     busy, done, pass, stim, mismatch_cnt, first_fail, first_fail_vld);
        end
        // start together with reset: reset wins
        start = 1'b1;
        tick();
        start = 1'b0;
        rst = 1'b0;
        tick();
        checks++;
        if (busy !== 0 || stim !== '0 || done !== 0) begin
            errors++;
            $display("FAIL rst_start: busy=%b stim=%0d done=%b, expected idle", busy, stim, done);
        end
    endtask

    task automatic test_all_pass();
        tbl_a = OR_TBL; tbl_b = OR_TBL;
        do_sweep("all_pass", 0);
    endtask

    task automatic test_single_fail();
        tbl_a = OR_TBL; tbl_b = OR_TBL ^ 4'b0100;
        do_sweep("single_fail", 0);
    endtask

    task automatic test_and_or();
        tbl_a = OR_TBL; tbl_b = AND_TBL;
        do_sweep("and_or", 0);
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        tbl_a = OR_TBL; tbl_b = AND_TBL;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 0;
        for (int c = 0; c < BUDGET; c++) begin
            if (stim === 2'b10) begin
                found = 1;
                break;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (!found || busy !== 0 || done !== 0 || stim !== '0 || mismatch_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: found=%b busy=%b done=%b stim=%0d cnt=%0d, expected 1 0 0 0 0",
                     found, busy, done, stim, mismatch_cnt);
        end
        tbl_b = OR_TBL;
        do_sweep("after_reset", 0);
    endtask

    task automatic test_back_to_back();
        tbl_a = OR_TBL; tbl_b = AND_TBL;
        do_sweep("busy_start", 3);
        tick(); tick();
        tbl_b = OR_TBL;
        do_sweep("done_restart", 0);
    endtask

    task automatic test_golden();
        tbl_a = '0; tbl_b = '0;
        do_sweep("const_zero", 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            tbl_a = COMBOS'($urandom);
            tbl_b = ($urandom_range(0, 2) == 0) ? tbl_a : COMBOS'($urandom);
            do_sweep("random", ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, SWEEP - 1)) : 0);
            for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
        end
    endtask

    initial begin
        tbl_a = OR_TBL; tbl_b = OR_TBL;
        test_reset();
        test_all_pass();
        test_single_fail();
        test_and_or();
        test_reset_mid_sweep();
        test_back_to_back();
        test_golden();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Sequential stimulus driver and response checker for the gate exercises, e.g. the NAND-built disjunction paired with its expression-based twin.
- It does in hardware what the bench does by hand: walks every input combination, waits for the logic to settle, and samples two candidate outputs.
- It compares those outputs, counts disagreements and reports pass/fail.
- It sits on the other side of the DUT pair: it drives their inputs and consumes their outputs.

Parameters:
- N, 2, number of DUT inputs; 2^N combinations are swept.
- SETTLE, 1, clock cycles stim is held before sampling (>=1).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a sweep when idle or done.
- stim  output  N  input vector driven to both DUTs.
- resp_a  input  1  output of gate-level DUT.
- resp_b  input  1  output of expression-level DUT.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep end until next start or reset.
- pass  output  1  valid when done; 1 if zero mismatches.
- mismatch_cnt  output  N+1  number of failing combinations.
- first_fail  output  N  stim value of first failing combination.
- first_fail_vld  output  1  first_fail holds a captured value.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE, stim=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, first_fail_vld=0, settle counter=0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - On start, clear mismatch_cnt, first_fail, first_fail_vld and pass.
  - Set stim=0, busy=1, go to DRIVE.
  - start is ignored in all other states except DONE.
- DRIVE:
  - stim is stable.
  - The settle counter counts SETTLE cycles, then the FSM goes to SAMPLE.
  - Each combination therefore occupies SETTLE+1 cycles.
- SAMPLE:
  - A mismatch is resp_a != resp_b, with X/Z on either input treated as a mismatch (use !==).
  - On a mismatch, increment mismatch_cnt.
  - On a mismatch with first_fail_vld=0, also capture first_fail=stim and set first_fail_vld=1.
  - If stim == 2^N-1, go to DONE with no wrap and no extra sample.
  - Otherwise stim = stim+1 (N-bit) and go to DRIVE.
- DONE:
  - busy=0, done=1.
  - pass=1 iff mismatch_cnt==0 after the final sample; the final sample is included in pass.
  - stim holds 2^N-1.
  - start restarts exactly as from IDLE, clearing results in the same cycle done drops.
- Total sweep latency from start to done rising: 2^N*(SETTLE+1)+1 cycles.
- Widths: mismatch_cnt is N+1 bits, maximum value 2^N, no overflow possible.
- Reset mid-sweep: rst has priority over start and all transitions. Any state goes to the reset values next edge and partial results are discarded.
- start and rst asserted together: rst wins and the FSM stays in IDLE.

Optional Feature:
- Macro: TRUTH_TABLE_GOLDEN_EN.
- When defined:
  - An internal golden value g = |stim (OR-reduction, the disjunction reference) is computed.
  - A combination fails if resp_a!==g or resp_b!==g, so identically wrong DUTs are caught.
  - An extra output golden_fail (1 bit, reset 0) is set sticky when a failure is against g. It is cleared on start.
- When undefined:
  - Only resp_a vs resp_b is compared.
  - golden_fail does not exist.

Test Plan:
- Both responses tied to |stim, N=2, SETTLE=1, start pulse:
  - done rises 9 cycles after start.
  - pass=1, mismatch_cnt=0, first_fail_vld=0.
  - stim visits 0,1,2,3.
- resp_b forced to ~resp_a only when stim==2'b10:
  - mismatch_cnt=1, first_fail=2'b10, first_fail_vld=1, pass=0.
- resp_a=|stim, resp_b=&stim (the AND/OR confusion):
  - mismatch_cnt=2, first_fail=2'b01, pass=0.
- rst asserted during DRIVE of stim=2'b10:
  - Next edge gives busy=0, done=0, stim=0, mismatch_cnt=0.
  - A subsequent start gives a full clean sweep, pass=1.
- start pulsed while busy, then again in DONE after a failing run:
  - The busy pulse is ignored, with no restart and an unchanged stim sequence.
  - The DONE pulse clears mismatch_cnt to 0 and re-sweeps.
- With TRUTH_TABLE_GOLDEN_EN, both responses constant 0:
  - mismatch_cnt=3, golden_fail=1, first_fail=2'b01.
  - Without the macro the same stimulus gives pass=1.
